// File: rtl/microseq_pkg.sv
// Microsequencer shared definitions: widths, COND codes, FSM states.
package microseq_pkg;

  localparam int DEF_UADDR_W    = 11;
  localparam int DEF_DECODEOP_W = 8;
  localparam int DEF_COND_W     = 3;
  localparam int DEF_ACK_TIMEOUT = 255;
  localparam int WAIT_CNT_W     = 8;

  localparam logic [2:0] COND_SEQ    = 3'd0;
  localparam logic [2:0] COND_N      = 3'd1;
  localparam logic [2:0] COND_Z      = 3'd2;
  localparam logic [2:0] COND_V      = 3'd3;
  localparam logic [2:0] COND_C      = 3'd4;
  localparam logic [2:0] COND_IR13   = 3'd5;
  localparam logic [2:0] COND_JMP    = 3'd6;
  localparam logic [2:0] COND_DECODE = 3'd7;

  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/microseq_next_addr.sv
// Next control-store address mux, selected by the microword COND field.
// Branch tests read the registered PSR only.
module microseq_next_addr
  import microseq_pkg::*;
#(
  parameter int UADDR_W    = DEF_UADDR_W,
  parameter int DECODEOP_W = DEF_DECODEOP_W,
  parameter int COND_W     = DEF_COND_W
) (
  input  logic [COND_W-1:0]     cond,
  input  logic [UADDR_W-1:0]    uAddr,
  input  logic [UADDR_W-1:0]    jumpAddr,
  input  logic [3:0]            psr,
  input  logic                  ir13,
  input  logic [DECODEOP_W-1:0] decodeOp,
  output logic [UADDR_W-1:0]    nextAddr
);

  logic [UADDR_W-1:0] seqAddr;
  logic [UADDR_W-1:0] decAddr;

  assign seqAddr = uAddr + UADDR_W'(1);
  assign decAddr = UADDR_W'({1'b1, decodeOp, 2'b00});

  always_comb begin
    nextAddr = seqAddr;
    unique case (1'b1)
      cond == COND_W'(COND_SEQ):
        nextAddr = seqAddr;
      cond == COND_W'(COND_N):
        nextAddr = psr[PSR_N] ? jumpAddr : seqAddr;
      cond == COND_W'(COND_Z):
        nextAddr = psr[PSR_Z] ? jumpAddr : seqAddr;
      cond == COND_W'(COND_V):
        nextAddr = psr[PSR_V] ? jumpAddr : seqAddr;
      cond == COND_W'(COND_C):
        nextAddr = psr[PSR_C] ? jumpAddr : seqAddr;
      cond == COND_W'(COND_IR13):
        nextAddr = ir13 ? jumpAddr : seqAddr;
      cond == COND_W'(COND_JMP):
        nextAddr = jumpAddr;
      cond == COND_W'(COND_DECODE):
        nextAddr = decAddr;
      default:
        nextAddr = seqAddr;
    endcase
  end

endmodule

// File: rtl/microseq.sv
// Microsequencer: control-store address register, PSR latch and
// memory-handshake FSM with ACK timeout fault.
module microseq
  import microseq_pkg::*;
#(
  parameter int DATAWIDTH_UADDR    = DEF_UADDR_W,
  parameter int DATAWIDTH_DECODEROP = DEF_DECODEOP_W,
  parameter int DATAWIDTH_COND     = DEF_COND_W,
  parameter int ACK_TIMEOUT        = DEF_ACK_TIMEOUT
) (
  input  logic                           MICROSEQ_CLOCK_50,
  input  logic                           MICROSEQ_ResetInHigh_In,
  input  logic [DATAWIDTH_COND-1:0]      MICROSEQ_UCond_InBus,
  input  logic [DATAWIDTH_UADDR-1:0]     MICROSEQ_UJumpAddr_InBus,
  input  logic                           MICROSEQ_URD_In,
  input  logic                           MICROSEQ_UWR_In,
  input  logic                           MICROSEQ_SetCodes_In,
  input  logic                           MICROSEQ_ACK_In,
  input  logic [DATAWIDTH_DECODEROP-1:0] MICROSEQ_DecodeOP_InBus,
  input  logic                           MICROSEQ_IR13_In,
  input  logic                           MICROSEQ_FlagNegative_In,
  input  logic                           MICROSEQ_FlagZero_In,
  input  logic                           MICROSEQ_FlagOverflow_In,
  input  logic                           MICROSEQ_FlagCarry_In,
  output logic [DATAWIDTH_UADDR-1:0]     MICROSEQ_UAddr_OutBus,
  output logic [3:0]                     MICROSEQ_PSR_OutBus,
  output logic                           MICROSEQ_Stall_Out,
  output logic                           MICROSEQ_Fault_Out
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'(ACK_TIMEOUT - 1);

  state_t                   state;
  logic [WAIT_CNT_W-1:0]    waitCnt;
  logic [DATAWIDTH_UADDR-1:0] uAddr;
  logic [DATAWIDTH_UADDR-1:0] nextAddr;
  logic [3:0]               psr;
  logic                     fault;
  logic                     memReq;
  logic                     stall;

  assign memReq = MICROSEQ_URD_In | MICROSEQ_UWR_In;
  // An ACK in the request cycle completes the access with no stall.
  assign stall  = (state == ST_FAULT) | (memReq & ~MICROSEQ_ACK_In);

  microseq_next_addr #(
    .UADDR_W    (DATAWIDTH_UADDR),
    .DECODEOP_W (DATAWIDTH_DECODEROP),
    .COND_W     (DATAWIDTH_COND)
  ) uNextAddr (
    .cond     (MICROSEQ_UCond_InBus),
    .uAddr    (uAddr),
    .jumpAddr (MICROSEQ_UJumpAddr_InBus),
    .psr      (psr),
    .ir13     (MICROSEQ_IR13_In),
    .decodeOp (MICROSEQ_DecodeOP_InBus),
    .nextAddr (nextAddr)
  );

  always_ff @(posedge MICROSEQ_CLOCK_50 or posedge MICROSEQ_ResetInHigh_In) begin
    if (MICROSEQ_ResetInHigh_In) begin
      state   <= ST_RUN;
      waitCnt <= '0;
      uAddr   <= '0;
      psr     <= 4'b0000;
      fault   <= 1'b0;
    end else begin
      if (!stall) begin
        uAddr <= nextAddr;
        if (MICROSEQ_SetCodes_In) begin
          psr <= {MICROSEQ_FlagNegative_In, MICROSEQ_FlagZero_In,
                  MICROSEQ_FlagOverflow_In, MICROSEQ_FlagCarry_In};
        end
      end
      unique case (state)
        ST_RUN: begin
          if (memReq && !MICROSEQ_ACK_In) begin
            state   <= ST_WAIT;
            waitCnt <= '0;
          end
        end
        ST_WAIT: begin
          if (!memReq || MICROSEQ_ACK_In) begin
            state <= ST_RUN;
          end else if (waitCnt == LAST_WAIT) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign MICROSEQ_UAddr_OutBus = uAddr;
  assign MICROSEQ_PSR_OutBus   = psr;
  assign MICROSEQ_Stall_Out    = stall;
  assign MICROSEQ_Fault_Out    = fault;

endmodule

// File: tb/tb_microseq.sv
// Randomized bench for microseq against a cycle-level behavioural model,
// plus directed wrap, decode, branch, wait, timeout and async-reset cases.
module tb_microseq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic        urd, uwr, setc, ack;
  logic [7:0]  dop;
  logic        ir13, fn, fz, fv, fc;
  logic [10:0] uAddr;
  logic [3:0]  psr;
  logic        stall, fault;

  int checks   = 0;
  int failures = 0;

  int mAddr;
  int mPsr;
  int mWait;
  bit mFault;

  always #5 clk = ~clk;

  microseq dut (
    .MICROSEQ_CLOCK_50        (clk),
    .MICROSEQ_ResetInHigh_In  (rst),
    .MICROSEQ_UCond_InBus     (cond),
    .MICROSEQ_UJumpAddr_InBus (jump),
    .MICROSEQ_URD_In          (urd),
    .MICROSEQ_UWR_In          (uwr),
    .MICROSEQ_SetCodes_In     (setc),
    .MICROSEQ_ACK_In          (ack),
    .MICROSEQ_DecodeOP_InBus  (dop),
    .MICROSEQ_IR13_In         (ir13),
    .MICROSEQ_FlagNegative_In (fn),
    .MICROSEQ_FlagZero_In     (fz),
    .MICROSEQ_FlagOverflow_In (fv),
    .MICROSEQ_FlagCarry_In    (fc),
    .MICROSEQ_UAddr_OutBus    (uAddr),
    .MICROSEQ_PSR_OutBus      (psr),
    .MICROSEQ_Stall_Out       (stall),
    .MICROSEQ_Fault_Out       (fault)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int psrBit(int idx);
    return (mPsr >> idx) & 1;
  endfunction

  // Reference next address straight from the COND table.
  function automatic int modelNext();
    int inc;
    inc = (mAddr + 1) % 2048;
    case (int'(cond))
      0: return inc;
      1: return psrBit(3) != 0 ? int'(jump) : inc;
      2: return psrBit(2) != 0 ? int'(jump) : inc;
      3: return psrBit(1) != 0 ? int'(jump) : inc;
      4: return psrBit(0) != 0 ? int'(jump) : inc;
      5: return ir13 ? int'(jump) : inc;
      6: return int'(jump);
      default: return 1024 + int'(dop) * 4;
    endcase
  endfunction

  task automatic modelReset();
    mAddr  = 0;
    mPsr   = 0;
    mWait  = 0;
    mFault = 0;
  endtask

  task automatic clearIn();
    cond = 3'd0; jump = '0; urd = 0; uwr = 0; setc = 0; ack = 0;
    dop = '0; ir13 = 0; fn = 0; fz = 0; fv = 0; fc = 0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step(string tag);
    bit req;
    bit mStall;
    req    = urd | uwr;
    mStall = mFault || (req && !ack);
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(mStall));
    @(posedge clk);
    if (!mStall) begin
      mAddr = modelNext();
      if (setc) mPsr = {28'd0, fn, fz, fv, fc};
    end
    if (!mFault) begin
      if (req && !ack) begin
        mWait++;
        if (mWait == 256) mFault = 1;
      end else begin
        mWait = 0;
      end
    end
    @(negedge clk);
    check({tag, ".uaddr"}, 32'(uAddr), 32'(mAddr));
    check({tag, ".psr"}, 32'(psr), 32'(mPsr));
    check({tag, ".fault"}, 32'(fault), 32'(mFault));
  endtask

  task automatic doReset(string tag);
    rst = 1'b1;
    modelReset();
    #1;
    check({tag, ".uaddr"}, 32'(uAddr), 0);
    check({tag, ".psr"}, 32'(psr), 0);
    check({tag, ".fault"}, 32'(fault), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int a;
    int n;
    clearIn();
    rst = 1'b1;
    modelReset();
    #2;
    check("reset.uaddr", 32'(uAddr), 0);
    check("reset.psr", 32'(psr), 0);
    check("reset.fault", 32'(fault), 0);
    check("reset.stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap: jump to 2046 then sequence.
    cond = 3'd6; jump = 11'd2046;
    step("wrap.jmp");
    cond = 3'd0;
    step("wrap.s1"); check("wrap.2047", 32'(uAddr), 2047);
    step("wrap.s2"); check("wrap.0", 32'(uAddr), 0);
    step("wrap.s3"); check("wrap.1", 32'(uAddr), 1);

    cond = 3'd7; dop = 8'h9C;
    step("decode"); check("decode.addr", 32'(uAddr), 32'h670);

    // Branch on registered Z.
    cond = 3'd0; setc = 1; fz = 1;
    step("br.set");
    cond = 3'd2; jump = 11'd100; setc = 0; fz = 0;
    step("br.take"); check("br.taken", 32'(uAddr), 100);
    setc = 1; fz = 0; cond = 3'd0;
    step("br.clr");
    a = mAddr;
    cond = 3'd2; jump = 11'd500; setc = 1; fz = 1;
    step("br.same"); check("br.nottaken", 32'(uAddr), 32'((a + 1) % 2048));

    // Memory wait: ACK five cycles late.
    clearIn();
    urd = 1;
    a = mAddr;
    for (int i = 0; i < 5; i++) begin
      step("wait.hold");
      check("wait.held", 32'(uAddr), 32'(a));
    end
    ack = 1;
    step("wait.ack"); check("wait.adv", 32'(uAddr), 32'((a + 1) % 2048));
    step("wait.zero"); check("wait.zeroadv", 32'(uAddr), 32'((a + 2) % 2048));

    // Timeout with ACK never arriving.
    clearIn();
    uwr = 1; setc = 1; fn = 1;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      step("tmo");
      if (fault === 1'b1) begin
        n = i;
        break;
      end
    end
    check("tmo.edges", 32'(n), 256);
    uwr = 0; ack = 1;
    step("tmo.absorb");
    doReset("tmo.reset");
    clearIn();
    step("tmo.run");

    // Async reset mid-wait, between edges.
    cond = 3'd6; jump = 11'd321; setc = 1; fn = 1; fc = 1;
    step("ar.pre");
    clearIn();
    urd = 1;
    step("ar.w1");
    step("ar.w2");
    #2;
    doReset("ar.reset");
    clearIn();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cond = 3'($urandom_range(0, 7));
      jump = 11'($urandom);
      dop  = 8'($urandom);
      urd  = ($urandom_range(0, 7) == 0);
      uwr  = ($urandom_range(0, 9) == 0);
      ack  = 1'($urandom_range(0, 1));
      setc = 1'($urandom_range(0, 1));
      ir13 = 1'($urandom);
      fn = 1'($urandom); fz = 1'($urandom);
      fv = 1'($urandom); fc = 1'($urandom);
      step("rand");
      if (mFault) doReset("rand.reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
